regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, two-read CPU register file.
- Adds configurable width and depth, N read ports, M write ports with fixed priority, and optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard (reserve at issue, release at writeback) plus a debug read port.
- Sits between the decode/issue stage and writeback in the multi-issue datapath.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of 2, at least 2).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 = a read sees same-cycle write data; 0 = a read sees the pre-edge value.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero.
- AW, $clog2(NREGS), address width (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data (combinational).
- rd_busy  out  NRD  busy flag of each read register (combinational).
- we  in  NWR  per-port write enable.
- wa  in  NWR*AW  packed write addresses.
- wd  in  NWR*XLEN  packed write data.
- rsv_en  in  1  reserve a destination register (set its busy bit).
- rsv_addr  in  AW  register to reserve.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data; never bypassed.
- busy_vec  out  NREGS  full scoreboard, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers and all busy bits clear to 0 immediately.
  - busy_vec=0; rd_data, rd_busy and dbg_data therefore read 0.
  - held in reset: clock edges have no effect.
  - reset asserted mid-write: the write is lost.
- Writes:
  - on the rising edge, RF[wa[j]] <= wd[j] for each j with we[j]=1.
  - two or more ports writing the same address: the highest-index port wins.
- Reads:
  - zero-latency combinational.
  - rd_data[k] = RF[rd_addr[k]] from pre-edge state.
  - if BYPASS=1 and some enabled write port matches rd_addr[k], rd_data[k] takes that port's wd (highest-index match), in the same cycle.
- ZERO_REG=1:
  - reads of address 0 return 0.
  - writes to address 0 are discarded and do not shadow lower-priority ports writing other addresses.
  - reserves of address 0 are ignored; busy[0] stays 0.
  - bypass never applies to address 0.
- Scoreboard:
  - on the edge, busy[a] clears for each enabled write address a.
  - busy[rsv_addr] sets when rsv_en=1.
  - reserve and write to the same address in the same cycle: busy ends at 1 (the new producer wins); the data is still written.
- Busy flags:
  - rd_busy[k] = busy[rd_addr[k]], except when BYPASS=1 and a write to that address is in flight this cycle: then rd_busy[k]=0.
  - a same-cycle reserve does not affect rd_busy until the next cycle.
- dbg_data = RF[dbg_addr] (pre-edge value; 0 for address 0 when ZERO_REG=1).
- No X propagation: out-of-range addresses are impossible by construction (NREGS = 2^AW).

Decomposition:
- Package regfile_pkg holds:
  - default XLEN/NREGS constants;
  - a clog2 function;
  - a localparam for the zero-register index.
- Sub-module regfile_scoreboard holds the busy-bit array and reserve/release logic; ports are clk, reset, the we/wa vectors, rsv_en, rsv_addr and busy_vec.
- Storage, write-priority and bypass muxes stay in regfile_mp.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse reset low mid-cycle -> rd_data for r5 is 0 at once and busy_vec=0.
- Write conflict: we=2'b11, wa={7,7}, wd={0x22,0x11} -> after the edge, RF[7] reads 0x22.
- Bypass: BYPASS=1, port 0 writes 0x1234 to r3 while read port 1 reads r3 -> rd_data[1]=0x1234 in the same cycle. With BYPASS=0 it reads the old value, then 0x1234 one cycle later.
- Zero register:
  - we[0] writing 0xFFFF to r0 -> reads return 0.
  - rsv_en with rsv_addr=0 -> busy_vec[0]=0.
- Scoreboard:
  - reserve r9 -> rd_busy=1 on the next cycle.
  - write r9 -> busy clears after the edge; a same-cycle read with BYPASS=1 shows rd_busy=0.
  - reserve and write r9 together -> busy_vec[9]=1 after the edge.
- Debug port: dbg_addr=31 after writing 0xA5A5A5A5 to r31 -> dbg_data=0xA5A5A5A5, and dbg_data does not change during a same-cycle write to r31.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
//   XLEN_DEF  : default data width in bits
//   NREGS_DEF : default number of architectural registers
//   ZERO_IDX  : index of the register hardwired to zero when ZERO_REG=1
//   clog2()   : address width for a given register count
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_IDX  = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for the multi-port register file.
// A register is reserved when an instruction naming it as destination issues,
// and released when any write port writes it back.
// Ports:
//   clk, reset (async, active-low)
//   we / wa    : write-back enables and packed addresses (release)
//   rsv_en     : reserve request, rsv_addr : register to reserve
//   busy_vec   : registered busy bit of every register
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Releases are applied before the reserve, so a reserve and a write-back
  // of the same register in one cycle leaves it busy: the newly issued
  // producer owns the register from here on.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) busy_d[wa[j*AW +: AW]] = 1'b0;
    end
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with busy scoreboard.
// Ports:
//   clk, reset (async, active-low)
//   rd_addr/rd_data/rd_busy : NRD combinational read ports (packed per port)
//   we/wa/wd                : NWR write ports, highest index wins on conflict
//   rsv_en/rsv_addr         : reserve a destination register (busy bit set)
//   dbg_addr/dbg_data       : debug read of committed state, never bypassed
//   busy_vec                : full registered scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic [NWR-1:0]  we_eff;

  // Writes aimed at the zero register are dropped per port, so they never
  // shadow a lower-priority port writing a different register and never
  // feed the bypass path.
  always_comb begin
    we_eff = '0;
    for (int j = 0; j < NWR; j++) begin
      we_eff[j] = we[j] && !((ZERO_REG != 0) && (wa[j*AW +: AW] == AW'(ZERO_IDX)));
    end
  end

  // Ascending port order: a later (higher-index) port overwrites earlier ones.
  always_comb begin
    rf_d = rf_q;
    for (int j = 0; j < NWR; j++) begin
      if (we_eff[j]) rf_d[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wa       (wa),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec)
  );

  // Read ports: committed value, then (with BYPASS) the highest-index
  // matching write overrides it; an in-flight write also hides the busy bit
  // since the value being read is the one that releases it.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_data[k*XLEN +: XLEN] = rf_q[rd_addr[k*AW +: AW]];
      rd_busy[k]              = busy_vec[rd_addr[k*AW +: AW]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (we_eff[j] && (wa[j*AW +: AW] == rd_addr[k*AW +: AW])) begin
            rd_data[k*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
            rd_busy[k]              = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[k*AW +: AW] == AW'(ZERO_IDX))) begin
        rd_data[k*XLEN +: XLEN] = '0;
        rd_busy[k]              = 1'b0;
      end
    end
  end

  assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == AW'(ZERO_IDX))) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances share all inputs, one with the
// same-cycle bypass and one without, so each vector checks both read paths.
module tb_regfile_mp;

  localparam int EW = 196;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [4:0]  dbg_addr;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [31:0] dbg_b, dbg_n;
  logic [31:0] bv_b, bv_n;

  int n_checks;
  int n_fail;
  logic [EW-1:0] exp_q[$];

  regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_b), .busy_vec(bv_b)
  );

  regfile_mp #(.BYPASS(0)) u_nob (
    .clk(clk), .reset(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_n), .busy_vec(bv_n)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  dbg;
    logic [31:0] e_rd0_b;
    logic [31:0] e_rd1_b;
    logic [1:0]  e_rb_b;
    logic [31:0] e_rd0_n;
    logic [31:0] e_rd1_n;
    logic [1:0]  e_rb_n;
    logic [31:0] e_dbg;
    logic [31:0] e_bv;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    we = '0; wa = '0; wd = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic apply(input vec_t v);
    we       = v.we;
    wa       = {v.wa1, v.wa0};
    wd       = {v.wd1, v.wd0};
    rsv_en   = v.rsv_en;
    rsv_addr = v.rsv_addr;
    rd_addr  = {v.ra1, v.ra0};
    dbg_addr = v.dbg;
    exp_q.push_back({v.e_rd0_b, v.e_rd1_b, v.e_rb_b, v.e_rd0_n, v.e_rd1_n,
                     v.e_rb_n, v.e_dbg, v.e_bv});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare_vec(input int idx);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL v%0d queue: got empty expected entry", idx);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("v%0d rd0_byp", idx),  rd_data_b[31:0],  e[195:164]);
    check($sformatf("v%0d rd1_byp", idx),  rd_data_b[63:32], e[163:132]);
    check($sformatf("v%0d busy_byp", idx), {30'd0, rd_busy_b}, {30'd0, e[131:130]});
    check($sformatf("v%0d rd0_nob", idx),  rd_data_n[31:0],  e[129:98]);
    check($sformatf("v%0d rd1_nob", idx),  rd_data_n[63:32], e[97:66]);
    check($sformatf("v%0d busy_nob", idx), {30'd0, rd_busy_n}, {30'd0, e[65:64]});
    check($sformatf("v%0d dbg_byp", idx),  dbg_b, e[63:32]);
    check($sformatf("v%0d dbg_nob", idx),  dbg_n, e[63:32]);
    check($sformatf("v%0d bvec_byp", idx), bv_b,  e[31:0]);
    check($sformatf("v%0d bvec_nob", idx), bv_n,  e[31:0]);
  endtask

  // ---------------- test ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;

    //          we     wa0    wd0           wa1    wd1           rsv   raddr  ra0    ra1    dbg    rd0_b         rd1_b         rb_b   rd0_n         rd1_n         rb_n   dbg           busy_vec
    vecs[0]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  5'd5,  32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0};
    // conflict: both ports write r7, port 1 wins
    vecs[1]  = '{2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       1'b0, 5'd0,  5'd7,  5'd7,  5'd7,  32'h22,       32'h22,       2'b00, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0};
    vecs[2]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  5'd7,  32'h22,       32'h22,       2'b00, 32'h22,       32'h22,       2'b00, 32'h22,       32'h0};
    // port 0 writes r3 while read port 1 reads it
    vecs[3]  = '{2'b01, 5'd3,  32'h1234,     5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd3,  5'd3,  32'h0,        32'h1234,     2'b00, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0};
    vecs[4]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd3,  5'd3,  32'h22,       32'h1234,     2'b00, 32'h22,       32'h1234,     2'b00, 32'h1234,     32'h0};
    // port 1 writes r0 (dropped, must not shadow port 0 -> r4); reserve r0 ignored
    vecs[5]  = '{2'b11, 5'd4,  32'h44,       5'd0,  32'hFFFF,     1'b1, 5'd0,  5'd0,  5'd4,  5'd0,  32'h0,        32'h44,       2'b00, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0};
    vecs[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd4,  5'd0,  32'h0,        32'h44,       2'b00, 32'h0,        32'h44,       2'b00, 32'h0,        32'h0};
    // reserve r9: not visible until next cycle
    vecs[7]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0};
    vecs[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        2'b11, 32'h0,        32'h0,        2'b11, 32'h0,        32'h200};
    // write-back r9 releases busy
    vecs[9]  = '{2'b10, 5'd0,  32'h0,        5'd9,  32'h99,       1'b0, 5'd0,  5'd9,  5'd9,  5'd9,  32'h99,       32'h99,       2'b00, 32'h0,        32'h0,        2'b11, 32'h0,        32'h200};
    vecs[10] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  5'd9,  32'h99,       32'h99,       2'b00, 32'h99,       32'h99,       2'b00, 32'h99,       32'h0};
    // reserve and write r9 together: data written, busy ends set
    vecs[11] = '{2'b01, 5'd9,  32'h9A,       5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  5'd9,  32'h9A,       32'h9A,       2'b00, 32'h99,       32'h99,       2'b00, 32'h99,       32'h0};
    vecs[12] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  5'd9,  32'h9A,       32'h9A,       2'b11, 32'h9A,       32'h9A,       2'b11, 32'h9A,       32'h200};
    // debug port on r31
    vecs[13] = '{2'b01, 5'd31, 32'hA5A5A5A5, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd9,  5'd31, 32'hA5A5A5A5, 32'h9A,       2'b10, 32'h0,        32'h9A,       2'b10, 32'h0,        32'h200};
    vecs[14] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd7,  5'd31, 32'hA5A5A5A5, 32'h22,       2'b00, 32'hA5A5A5A5, 32'h22,       2'b00, 32'hA5A5A5A5, 32'h200};
    vecs[15] = '{2'b10, 5'd0,  32'h0,        5'd31, 32'h0BADF00D, 1'b0, 5'd0,  5'd31, 5'd31, 5'd31, 32'h0BADF00D, 32'h0BADF00D, 2'b00, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'hA5A5A5A5, 32'h200};
    vecs[16] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd3,  5'd31, 32'h0BADF00D, 32'h1234,     2'b00, 32'h0BADF00D, 32'h1234,     2'b00, 32'h0BADF00D, 32'h200};

    // power-on reset
    rst_n = 1'b0;
    idle_inputs();
    rd_addr  = '0;
    dbg_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // reset sequence: write r5 and reserve r9, then reset mid-cycle
    @(posedge clk);
    #1;
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF};
    rsv_en = 1'b1; rsv_addr = 5'd9;
    rd_addr = {5'd5, 5'd5}; dbg_addr = 5'd5;
    @(posedge clk);
    #1;
    idle_inputs();
    check("pre_rst rd0_byp", rd_data_b[31:0], 32'hDEADBEEF);
    check("pre_rst rd0_nob", rd_data_n[31:0], 32'hDEADBEEF);
    check("pre_rst dbg",     dbg_b,           32'hDEADBEEF);
    check("pre_rst bvec",    bv_b,            32'h200);
    #2;
    we = 2'b01; wa = {5'd0, 5'd6}; wd = {32'h0, 32'h66};
    #1;
    rst_n = 1'b0;
    #1;
    check("rst rd0_byp",  rd_data_b[31:0], 32'h0);
    check("rst rd0_nob",  rd_data_n[31:0], 32'h0);
    check("rst dbg",      dbg_b,           32'h0);
    check("rst bvec_byp", bv_b,            32'h0);
    check("rst bvec_nob", bv_n,            32'h0);
    check("rst busy",     {30'd0, rd_busy_b}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd6, 5'd5};
    rst_n = 1'b1;
    #1;
    check("rst lost_wr_byp", rd_data_b[63:32], 32'h0);
    check("rst lost_wr_nob", rd_data_n[63:32], 32'h0);
    check("rst r5_cleared",  rd_data_b[31:0],  32'h0);

    // table-driven section
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i]);
      @(negedge clk);
      compare_vec(i);
    end

    @(posedge clk);
    #1;
    idle_inputs();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d leftover entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
